// File: rtl/ball_motion.sv
// Ball owner for the pong datapath: position, direction, speed, scores and
// the serve/game FSM. Movement is applied once per frame tick.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       leaves WAIT_START / GAME_OVER
//   coll_L/R/T/B                collision flags from the collision detector
//   reset_pt, score[1:0]        missed ball; 01 = point to P1, 10 = point to P2
//   ball_x[9:0], ball_y[8:0]    ball top-left corner, pixels
//   speed[2:0]                  pixels per tick per axis
//   score_p1[3:0], score_p2[3:0] player scores
//   moving, game_over           state decodes (MOVE, GAME_OVER)
module ball_motion #(
   parameter int unsigned FRAME_DIV    = 833333,
   parameter int unsigned X_START      = 296,
   parameter int unsigned Y_START      = 236,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned SPEEDUP_HITS = 4,
   parameter int unsigned SPEED_MAX    = 4,
   parameter int unsigned WIN_SCORE    = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       coll_L,
   input  logic       coll_R,
   input  logic       coll_T,
   input  logic       coll_B,
   input  logic       reset_pt,
   input  logic [1:0] score,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic [2:0] speed,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic       moving,
   output logic       game_over
);

   localparam int unsigned DIV_W = $clog2(FRAME_DIV);
   localparam int unsigned SRV_W = $clog2(SERVE_FRAMES + 1);
   localparam int unsigned HIT_W = $clog2(SPEEDUP_HITS + 1);
   localparam int unsigned X_MAX = 632;
   localparam int unsigned Y_MAX = 472;

   typedef enum logic [1:0] {WAIT_START, SERVE, MOVE, GAME_OVER} state_t;

   state_t             state, state_n;
   logic [DIV_W-1:0]   div_cnt, div_n;
   logic [SRV_W-1:0]   srv_cnt, srv_n;
   logic [HIT_W-1:0]   hits, hits_n, hits_inc;
   logic               dx, dx_n, dy, dy_n;
   logic [3:0]         pend, pend_n, flags;   // {L, R, T, B}
   logic [9:0]         ball_x_n;
   logic [8:0]         ball_y_n;
   logic [2:0]         speed_n;
   logic [3:0]         score_p1_n, score_p2_n;
   logic               moving_n, game_over_n;
   logic               tick;
   logic [10:0]        sum_x;
   logic [9:0]         sum_y;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= WAIT_START;
         div_cnt   <= '0;
         srv_cnt   <= '0;
         hits      <= '0;
         dx        <= 1'b1;
         dy        <= 1'b1;
         pend      <= '0;
         ball_x    <= 10'(X_START);
         ball_y    <= 9'(Y_START);
         speed     <= 3'd1;
         score_p1  <= '0;
         score_p2  <= '0;
         moving    <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_n;
         div_cnt   <= div_n;
         srv_cnt   <= srv_n;
         hits      <= hits_n;
         dx        <= dx_n;
         dy        <= dy_n;
         pend      <= pend_n;
         ball_x    <= ball_x_n;
         ball_y    <= ball_y_n;
         speed     <= speed_n;
         score_p1  <= score_p1_n;
         score_p2  <= score_p2_n;
         moving    <= moving_n;
         game_over <= game_over_n;
      end
   end

   // Next-state, movement and scoring
   always_comb begin
      state_n     = state;
      srv_n       = srv_cnt;
      hits_n      = hits;
      hits_inc    = hits + HIT_W'(1);
      dx_n        = dx;
      dy_n        = dy;
      pend_n      = pend;
      flags       = pend | {coll_L, coll_R, coll_T, coll_B};
      ball_x_n    = ball_x;
      ball_y_n    = ball_y;
      speed_n     = speed;
      score_p1_n  = score_p1;
      score_p2_n  = score_p2;
      sum_x       = '0;
      sum_y       = '0;

      tick  = (div_cnt == DIV_W'(FRAME_DIV - 1));
      div_n = tick ? '0 : div_cnt + DIV_W'(1);

      case (state)
         WAIT_START: begin
            ball_x_n = 10'(X_START);
            ball_y_n = 9'(Y_START);
            if (start) begin
               state_n = SERVE;
               srv_n   = '0;
            end
         end
         SERVE: begin
            ball_x_n = 10'(X_START);
            ball_y_n = 9'(Y_START);
            pend_n   = '0;
            if (tick) begin
               srv_n = srv_cnt + SRV_W'(1);
               if (srv_n == SRV_W'(SERVE_FRAMES)) state_n = MOVE;
            end
         end
         MOVE: begin
            pend_n = flags;
            // A valid miss outranks any tick or collision this cycle
            if (reset_pt && (score == 2'b01 || score == 2'b10)) begin
               ball_x_n = 10'(X_START);
               ball_y_n = 9'(Y_START);
               speed_n  = 3'd1;
               hits_n   = '0;
               pend_n   = '0;
               srv_n    = '0;
               if (score == 2'b01) begin
                  score_p1_n = score_p1 + 4'd1;
                  dx_n       = 1'b1;
                  state_n    = (score_p1_n == 4'(WIN_SCORE)) ? GAME_OVER : SERVE;
               end else begin
                  score_p2_n = score_p2 + 4'd1;
                  dx_n       = 1'b0;
                  state_n    = (score_p2_n == 4'(WIN_SCORE)) ? GAME_OVER : SERVE;
               end
            end else if (tick) begin
               // Directions are set (not toggled); opposing flags cancel
               if (flags[1] && !flags[0]) dy_n = 1'b1;
               else if (flags[0] && !flags[1]) dy_n = 1'b0;
               if (flags[3] && !flags[2]) dx_n = 1'b1;
               else if (flags[2] && !flags[3]) dx_n = 1'b0;
               if (flags[3] || flags[2]) begin
                  if (hits_inc == HIT_W'(SPEEDUP_HITS)) begin
                     hits_n = '0;
                     if (speed < 3'(SPEED_MAX)) speed_n = speed + 3'd1;
                  end else begin
                     hits_n = hits_inc;
                  end
               end
               if (dx_n) begin
                  sum_x    = {1'b0, ball_x} + 11'(speed_n);
                  ball_x_n = (sum_x > 11'(X_MAX)) ? 10'(X_MAX) : sum_x[9:0];
               end else begin
                  ball_x_n = (ball_x < 10'(speed_n)) ? 10'd0 : ball_x - 10'(speed_n);
               end
               if (dy_n) begin
                  sum_y    = {1'b0, ball_y} + 10'(speed_n);
                  ball_y_n = (sum_y > 10'(Y_MAX)) ? 9'(Y_MAX) : sum_y[8:0];
               end else begin
                  ball_y_n = (ball_y < 9'(speed_n)) ? 9'd0 : ball_y - 9'(speed_n);
               end
               pend_n = '0;
            end
         end
         GAME_OVER: begin
            ball_x_n = 10'(X_START);
            ball_y_n = 9'(Y_START);
            if (start) begin
               score_p1_n = '0;
               score_p2_n = '0;
               dx_n       = 1'b1;
               dy_n       = 1'b1;
               speed_n    = 3'd1;
               hits_n     = '0;
               srv_n      = '0;
               state_n    = SERVE;
            end
         end
         default: state_n = WAIT_START;
      endcase

      moving_n    = (state_n == MOVE);
      game_over_n = (state_n == GAME_OVER);
   end

endmodule

// File: tb/tb_ball_motion.sv
// Randomized self-checking bench for ball_motion against a behavioural model.
module tb_ball_motion;

   localparam int FDIV = 4;
   localparam int SRVF = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, c_l = 1'b0, c_r = 1'b0, c_t = 1'b0, c_b = 1'b0;
   logic       rpt = 1'b0;
   logic [1:0] sc = 2'b00;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic [2:0] speed;
   logic [3:0] score_p1, score_p2;
   logic       moving, game_over;

   int n_checks = 0;
   int n_pass   = 0;

   ball_motion #(.FRAME_DIV(FDIV), .SERVE_FRAMES(SRVF)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .coll_L(c_l), .coll_R(c_r), .coll_T(c_t), .coll_B(c_b),
      .reset_pt(rpt), .score(sc),
      .ball_x(ball_x), .ball_y(ball_y), .speed(speed),
      .score_p1(score_p1), .score_p2(score_p2),
      .moving(moving), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // Behavioural model of the game (phase: 0 wait, 1 serve, 2 move, 3 over)
   int m_phase, m_cnt, m_srv, m_x, m_y, m_dx, m_dy, m_spd, m_hits, m_p1, m_p2;
   bit m_pl, m_pr, m_pt, m_pb;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_srv = 0; m_x = 296; m_y = 236;
      m_dx = 1; m_dy = 1; m_spd = 1; m_hits = 0; m_p1 = 0; m_p2 = 0;
      {m_pl, m_pr, m_pt, m_pb} = 4'b0;
   endtask

   task automatic model_step();
      bit tick;
      tick  = (m_cnt == FDIV - 1);
      m_cnt = tick ? 0 : m_cnt + 1;
      if (m_phase == 0) begin
         if (start) begin m_phase = 1; m_srv = 0; end
      end else if (m_phase == 1) begin
         {m_pl, m_pr, m_pt, m_pb} = 4'b0;
         if (tick) begin
            m_srv++;
            if (m_srv == SRVF) m_phase = 2;
         end
      end else if (m_phase == 2) begin
         m_pl |= c_l; m_pr |= c_r; m_pt |= c_t; m_pb |= c_b;
         if (rpt && (sc == 2'b01 || sc == 2'b10)) begin
            if (sc == 2'b01) m_p1++; else m_p2++;
            m_dx = (sc == 2'b01);
            m_x = 296; m_y = 236; m_spd = 1; m_hits = 0; m_srv = 0;
            {m_pl, m_pr, m_pt, m_pb} = 4'b0;
            m_phase = (m_p1 == 9 || m_p2 == 9) ? 3 : 1;
         end else if (tick) begin
            if (m_pt != m_pb) m_dy = m_pt;
            if (m_pl != m_pr) m_dx = m_pl;
            if (m_pl || m_pr) begin
               m_hits++;
               if (m_hits == 4) begin
                  m_hits = 0;
                  if (m_spd < 4) m_spd++;
               end
            end
            m_x = m_dx ? m_x + m_spd : m_x - m_spd;
            m_y = m_dy ? m_y + m_spd : m_y - m_spd;
            if (m_x > 632) m_x = 632;
            if (m_x < 0)   m_x = 0;
            if (m_y > 472) m_y = 472;
            if (m_y < 0)   m_y = 0;
            {m_pl, m_pr, m_pt, m_pb} = 4'b0;
         end
      end else begin
         if (start) begin
            m_p1 = 0; m_p2 = 0; m_dx = 1; m_dy = 1; m_spd = 1; m_hits = 0;
            m_srv = 0; m_phase = 1;
         end
      end
   endtask

   // One clock: advance the model with the applied inputs, compare #1 later
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("ball_x", int'(ball_x), m_x);
      check("ball_y", int'(ball_y), m_y);
      check("speed", int'(speed), m_spd);
      check("score_p1", int'(score_p1), m_p1);
      check("score_p2", int'(score_p2), m_p2);
      check("moving", int'(moving), int'(m_phase == 2));
      check("game_over", int'(game_over), int'(m_phase == 3));
   endtask

   task automatic clear_inputs();
      start = 1'b0; c_l = 1'b0; c_r = 1'b0; c_t = 1'b0; c_b = 1'b0;
      rpt = 1'b0; sc = 2'b00;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      clear_inputs();
      rst_n = 1'b0;
      #1;
      check("rst_x", int'(ball_x), 296);
      check("rst_y", int'(ball_y), 236);
      check("rst_speed", int'(speed), 1);
      check("rst_scores", int'({score_p1, score_p2}), 0);
      check("rst_moving", int'(moving), 0);
      check("rst_game_over", int'(game_over), 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_moving(input int budget);
      int n = 0;
      while (moving !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check("wait_moving", int'(moving), 1);
   endtask

   initial begin
      model_reset();
      do_reset();

      // Idle with start low: ball stays at serve position
      repeat (100) step();
      check("idle_x", int'(ball_x), 296);
      check("idle_moving", int'(moving), 0);

      // Serve, then first movement step is +1/+1
      start = 1'b1; step(); start = 1'b0;
      wait_moving(40);
      for (int n = 0; n < 10 && ball_x == 10'd296; n++) step();
      check("first_x", int'(ball_x), 297);
      check("first_y", int'(ball_y), 237);

      // Paddle hits speed the ball up, then saturate at the maximum
      for (int i = 0; i < 16; i++) begin
         c_l = 1'b1; step(); c_l = 1'b0;
         repeat (4) step();
         if (i == 3) check("speed_after_4", int'(speed), 2);
      end
      check("speed_sat", int'(speed), 4);

      // A held miss with simultaneous right collision scores once
      rpt = 1'b1; sc = 2'b10; c_r = 1'b1;
      repeat (5) step();
      clear_inputs();
      check("p2_once", int'(score_p2), 1);
      check("miss_x", int'(ball_x), 296);
      check("miss_speed", int'(speed), 1);
      check("miss_serve", int'(moving), 0);
      wait_moving(40);
      for (int n = 0; n < 10 && ball_x == 10'd296; n++) step();
      check("serve_left_x", int'(ball_x), 295);

      // Nine points to P1 ends the game
      for (int i = 0; i < 9; i++) begin
         wait_moving(40);
         rpt = 1'b1; sc = 2'b01; step(); clear_inputs();
      end
      check("go_flag", int'(game_over), 1);
      check("go_p1", int'(score_p1), 9);
      rpt = 1'b1; sc = 2'b01; repeat (5) step(); clear_inputs();
      check("go_frozen", int'(score_p1), 9);
      start = 1'b1; step(); start = 1'b0;
      check("restart_p1", int'(score_p1), 0);
      check("restart_p2", int'(score_p2), 0);
      check("restart_go", int'(game_over), 0);

      // Randomized play with a mid-run asynchronous reset
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         start = ($urandom_range(0, 40) == 0);
         c_l   = ($urandom_range(0, 12) == 0);
         c_r   = ($urandom_range(0, 12) == 0);
         c_t   = ($urandom_range(0, 12) == 0);
         c_b   = ($urandom_range(0, 12) == 0);
         rpt   = ($urandom_range(0, 50) == 0);
         sc    = 2'($urandom_range(0, 3));
         step();
      end
      clear_inputs();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
